// File: rtl/prog_harness_loader.sv
// Test-harness wrapper: loads an image into data memory with the CPU in reset, runs the CPU
// until done or timeout, then streams a result window out of data memory.
module prog_harness_loader #(
  parameter int LOAD_COUNT   = 64,
  parameter int RESULT_BASE  = 64,
  parameter int RESULT_COUNT = 16,
  parameter int TIMEOUT      = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_reset,
  input  logic        cpu_done,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [15:0] run_cycles,
  output logic        finished,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [8:0]  LOAD_LAST = 9'(LOAD_COUNT - 1);
  localparam logic [8:0]  RES_LAST  = 9'(RESULT_COUNT - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  RES_BASE8 = 8'(RESULT_BASE % 256);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] run_cycles_q, run_cycles_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign run_cycles = run_cycles_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
    in_ready     = 1'b0;
    mem_sel      = 1'b1;
    mem_we       = 1'b0;
    mem_addr     = cnt_q[7:0];
    mem_wdata    = in_data;
    cpu_reset    = 1'b1;
    out_valid    = 1'b0;
    out_data     = mem_rdata;
    finished     = 1'b0;
    timeout_err  = 1'b0;

    // Outputs stay in their safe reset values while reset is held.
    if (!reset) begin
      unique case (state_q)
        S_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            mem_we = 1'b1;
            if (cnt_q == LOAD_LAST) begin
              cnt_d   = '0;
              state_d = S_START;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
        end
        S_START: begin
          // One extra reset edge for the CPU after the final image write.
          run_cycles_d = '0;
          state_d      = S_RUN;
        end
        S_RUN: begin
          mem_sel   = 1'b0;
          cpu_reset = 1'b0;
          if (run_cycles_q != 16'hFFFF) run_cycles_d = run_cycles_q + 16'd1;
          if (cpu_done) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else if (run_cycles_q == TO_LAST) begin
            state_d = S_ERR;
          end
        end
        S_DRAIN: begin
          mem_addr  = RES_BASE8 + cnt_q[7:0];
          out_valid = 1'b1;
          if (out_ready) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == RES_LAST) state_d = S_FIN;
          end
        end
        S_FIN: begin
          finished = 1'b1;
        end
        S_ERR: begin
          timeout_err = 1'b1;
        end
        default: begin
          state_d = S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_harness_loader.sv
// Randomized bench for prog_harness_loader: a default instance and a short-timeout instance
// with a result window that wraps past address 255, both checked against a byte-image model.
module tb_prog_harness_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, cpu_done, cpu_done2;
  logic [7:0]  in_data;

  logic        in_ready, mem_sel, mem_we, cpu_reset, out_valid, finished, timeout_err;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata, out_data;
  logic [15:0] run_cycles;

  logic        in_ready2, mem_sel2, mem_we2, cpu_reset2, out_valid2, finished2, timeout_err2;
  logic [7:0]  mem_addr2, mem_wdata2, mem_rdata2, out_data2;
  logic [15:0] run_cycles2;

  logic [7:0]  mem1 [256];
  logic [7:0]  mem2 [256];
  logic [7:0]  ref_img [256];
  logic        pre_we;
  logic [7:0]  pre_addr, pre_wdata;

  prog_harness_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_reset(cpu_reset), .cpu_done(cpu_done), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .run_cycles(run_cycles), .finished(finished),
    .timeout_err(timeout_err)
  );

  prog_harness_loader #(.LOAD_COUNT(64), .RESULT_BASE(250), .RESULT_COUNT(10), .TIMEOUT(100)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .mem_sel(mem_sel2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .cpu_reset(cpu_reset2), .cpu_done(cpu_done2), .out_valid(out_valid2),
    .out_data(out_data2), .out_ready(out_ready), .run_cycles(run_cycles2), .finished(finished2),
    .timeout_err(timeout_err2)
  );

  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_addr] <= pre_wdata;
      mem2[pre_addr] <= pre_wdata;
    end else begin
      if (mem_sel && mem_we)   mem1[mem_addr]  <= mem_wdata;
      if (mem_sel2 && mem_we2) mem2[mem_addr2] <= mem_wdata2;
    end
  end
  assign mem_rdata  = mem1[mem_addr];
  assign mem_rdata2 = mem2[mem_addr2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drain monitor for the wrapping instance: result k comes from address (250+k) mod 256.
  logic mon2 = 1'b0;
  int   k2   = 0;
  always @(negedge clk) begin
    if (mon2 && out_valid2 && out_ready) begin
      check($sformatf("d2_addr%0d", k2), mem_addr2, (250 + k2) % 256);
      check($sformatf("d2_data%0d", k2), out_data2, ref_img[(250 + k2) % 256]);
      k2++;
    end
  end

  int c, xfer, acc, n_run;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cpu_done = 1'b0; cpu_done2 = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_wdata = '0;

    for (int a = 0; a < 256; a++) begin
      tick();
      pre_we = 1'b1; pre_addr = 8'(a); pre_wdata = 8'($urandom); ref_img[a] = pre_wdata;
    end
    tick();
    pre_we = 1'b0; in_valid = 1'b1; in_data = 8'h5a; out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_sel", mem_sel, 1);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_finished", finished, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_run_cycles", run_cycles, 0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Round 1: gapless load of 0x10+i
    for (int i = 0; i < 64; i++) begin
      tick();
      in_valid = 1'b1; in_data = 8'(8'h10 + i); ref_img[i] = in_data;
      #1;
      check($sformatf("ld1_rdy%0d", i), in_ready, 1);
      check($sformatf("ld1_we%0d", i), mem_we, 1);
      check($sformatf("ld1_addr%0d", i), mem_addr, i);
      check($sformatf("ld1_wdata%0d", i), mem_wdata, 8'h10 + i);
    end
    tick();
    #1;
    check("st1_in_ready", in_ready, 0);
    check("st1_mem_we", mem_we, 0);
    check("st1_mem_sel", mem_sel, 1);
    check("st1_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 64; i++) check($sformatf("img1_%0d", i), mem1[i], ref_img[i]);
    in_valid = 1'b0;

    // Round 1 run: done on RUN cycle 200; short-timeout instance expires at 100
    for (int k = 1; k <= 200; k++) begin
      tick();
      cpu_done = (k == 200); cpu_done2 = (k == 150);
      #1;
      check($sformatf("run1_cyc%0d", k), run_cycles, k - 1);
      check($sformatf("run1_cpurst%0d", k), cpu_reset, 0);
      if (k == 1) check("run1_mem_sel", mem_sel, 0);
      if (k <= 100) begin
        check($sformatf("to_run_err%0d", k), timeout_err2, 0);
        check($sformatf("to_run_cpurst%0d", k), cpu_reset2, 0);
      end else begin
        check($sformatf("to_err%0d", k), timeout_err2, 1);
        check($sformatf("to_cpurst%0d", k), cpu_reset2, 1);
        check($sformatf("to_cyc%0d", k), run_cycles2, 100);
        check($sformatf("to_oval%0d", k), out_valid2, 0);
      end
    end

    // Round 1 drain: 3 stall cycles, then random backpressure
    c = 0; xfer = 0;
    while (xfer < 16 && c < 300) begin
      tick();
      cpu_done = 1'b0; cpu_done2 = 1'b0;
      out_ready = (c < 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      if (c == 0) begin
        check("dr1_cpu_reset", cpu_reset, 1);
        check("dr1_mem_sel", mem_sel, 1);
      end
      check($sformatf("dr1_valid_c%0d", c), out_valid, 1);
      check($sformatf("dr1_addr_c%0d", c), mem_addr, 64 + xfer);
      check($sformatf("dr1_data_c%0d", c), out_data, ref_img[64 + xfer]);
      check($sformatf("dr1_cyc_c%0d", c), run_cycles, 200);
      if (out_ready) xfer++;
      c++;
    end
    check("dr1_count", xfer, 16);
    for (int j = 0; j < 3; j++) begin
      tick();
      out_ready = 1'b1; cpu_done = (j == 1);
      #1;
      check($sformatf("fin1_%0d", j), finished, 1);
      check($sformatf("fin1_oval%0d", j), out_valid, 0);
      check($sformatf("fin1_inrdy%0d", j), in_ready, 0);
      check($sformatf("fin1_cyc%0d", j), run_cycles, 200);
      check($sformatf("to_sticky%0d", j), timeout_err2, 1);
    end
    cpu_done = 1'b0;

    // Round 2: reset, then load with in_valid on every other cycle
    tick();
    reset = 1'b1; out_ready = 1'b0;
    #1;
    check("rst2_finished", finished, 0);
    check("rst2_timeout2", timeout_err2, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst2_in_ready", in_ready, 1);
    check("rst2_addr", mem_addr, 0);
    check("rst2_cyc", run_cycles, 0);
    acc = 0; c = 0;
    while (acc < 64 && c < 400) begin
      if (c > 0) tick();
      in_valid = (c % 2 == 0); in_data = 8'($urandom);
      #1;
      check($sformatf("ld2_we_c%0d", c), mem_we, in_valid);
      check($sformatf("ld2_rdy_c%0d", c), in_ready, 1);
      if (in_valid) begin
        check($sformatf("ld2_addr%0d", acc), mem_addr, acc);
        ref_img[acc] = in_data;
        acc++;
      end
      c++;
    end
    tick();
    in_valid = 1'b1;
    #1;
    check("st2_in_ready", in_ready, 0);
    check("st2_mem_we", mem_we, 0);
    check("st2_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 64; i++) check($sformatf("img2_%0d", i), mem1[i], ref_img[i]);
    in_valid = 1'b0;

    // Round 2 run: done coincides with the timeout cycle on the short instance
    n_run = $urandom_range(150, 250);
    k2 = 0; mon2 = 1'b1;
    for (int k = 1; k <= n_run; k++) begin
      tick();
      cpu_done = (k == n_run); cpu_done2 = (k == 100);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check($sformatf("run2_cyc%0d", k), run_cycles, k - 1);
      if (k == 101) begin
        check("to_done_wins_err", timeout_err2, 0);
        check("to_done_wins_oval", out_valid2, 1);
        check("to_done_wins_cyc", run_cycles2, 100);
      end
    end
    check("d2_count", k2, 10);
    check("d2_finished", finished2, 1);

    // Round 2 drain: reset after 5 transfers
    c = 0; xfer = 0;
    while (xfer < 5 && c < 100) begin
      tick();
      cpu_done = 1'b0; cpu_done2 = 1'b0;
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      check($sformatf("dr2_addr_c%0d", c), mem_addr, 64 + xfer);
      check($sformatf("dr2_data_c%0d", c), out_data, ref_img[64 + xfer]);
      if (out_ready) xfer++;
      c++;
    end
    check("dr2_count", xfer, 5);
    tick();
    reset = 1'b1; out_ready = 1'b1;
    #1;
    check("rst3_out_valid", out_valid, 0);
    check("rst3_in_ready", in_ready, 0);
    check("rst3_mem_sel", mem_sel, 1);
    tick();
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("rst3_load_rdy", in_ready, 1);
    check("rst3_addr", mem_addr, 0);
    check("rst3_cyc", run_cycles, 0);
    check("rst3_finished", finished, 0);
    check("rst3_cpu_reset", cpu_reset, 1);
    check("rst3_finished2", finished2, 0);
    mon2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
